// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with busy scoreboard and clear sweep; define REGFILE_BYPASS_EN for same-cycle forwarding
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              rb0,
  output logic              rb1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic ok0, ok1, oks;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd_v [2];
  logic rb_v [2];
  assign ok0 = !(ZERO_REG != 0 && wa0 == '0);
  assign ok1 = !(ZERO_REG != 0 && wa1 == '0);
  assign oks = !(ZERO_REG != 0 && set_addr == '0);
  assign clr_busy = state == CLEAR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      clr_done <= 1'b0;
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      clr_done <= 1'b0;
      if (state == CLEAR) begin
        mem[cnt] <= '0;
        busy[cnt] <= 1'b0;
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= IDLE;
          clr_done <= 1'b1;
        end
      end else begin
        if (clr_req) begin
          state <= CLEAR;
          cnt <= '0;
        end
        if (we0 && ok0) begin
          mem[wa0] <= wd0;
          busy[wa0] <= 1'b0;
        end
        if (we1 && ok1) begin
          mem[wa1] <= wd1;
          busy[wa1] <= 1'b0;
        end
        if (set_busy && oks) busy[set_addr] <= 1'b1;
      end
    end
  end
  assign ra[0] = ra0;
  assign ra[1] = ra1;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic z, f0, f1, sb;
    assign z = ZERO_REG != 0 && ra[p] == '0;
`ifdef REGFILE_BYPASS_EN
    assign f0 = !clr_busy && we0 && wa0 == ra[p];
    assign f1 = !clr_busy && we1 && wa1 == ra[p];
    assign sb = !clr_busy && set_busy && set_addr == ra[p];
`else
    assign f0 = 1'b0;
    assign f1 = 1'b0;
    assign sb = 1'b0;
`endif
    assign rd_v[p] = z ? '0 : f1 ? wd1 : f0 ? wd0 : mem[ra[p]];
    assign rb_v[p] = z ? 1'b0 : sb ? 1'b1 : (f0 || f1) ? 1'b0 : busy[ra[p]];
  end
  assign rd0 = rd_v[0];
  assign rd1 = rd_v[1];
  assign rb0 = rb_v[0];
  assign rb1 = rb_v[1];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of writes, scoreboard, clear sweep, reset abort and bypass
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] ra0 = '0, ra1 = '0, wa0 = '0, wa1 = '0, set_addr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic we0 = 1'b0, we1 = 1'b0, set_busy = 1'b0, clr_req = 1'b0;
  logic [31:0] rd0, rd1;
  logic rb0, rb1, clr_busy, clr_done;
  int tests = 0;
  int fails = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .rb0(rb0), .rb1(rb1), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .set_busy(set_busy), .set_addr(set_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    we0 = 1'b0;
    we1 = 1'b0;
    set_busy = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ra0 = 5'd5;
    ra1 = 5'd31;
    tick();
    tick();
    tests++; if (rd0 !== 32'h0) begin fails++; $display("FAIL reset_rd0 got %h exp %h", rd0, 32'h0); end
    tests++; if (rb1 !== 1'b0) begin fails++; $display("FAIL reset_rb1 got %b exp 0", rb1); end
    tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL reset_clr_busy got %b exp 0", clr_busy); end
    tests++; if (clr_done !== 1'b0) begin fails++; $display("FAIL reset_clr_done got %b exp 0", clr_done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_reg();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h12345678;
    set_busy = 1'b1; set_addr = 5'd0;
    tick();
    quiet();
    ra0 = 5'd0;
    ra1 = 5'd5;
    #1;
    tests++; if (rd0 !== 32'h0) begin fails++; $display("FAIL zero_rd got %h exp %h", rd0, 32'h0); end
    tests++; if (rd1 !== 32'h12345678) begin fails++; $display("FAIL r5_rd got %h exp %h", rd1, 32'h12345678); end
    tests++; if (rb0 !== 1'b0) begin fails++; $display("FAIL zero_rb got %b exp 0", rb0); end
    tests++; if (rb1 !== 1'b0) begin fails++; $display("FAIL r5_rb got %b exp 0", rb1); end
  endtask

  task automatic test_conflict();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2;
    tick();
    wa0 = 5'd3; wd0 = 32'h33;
    wa1 = 5'd4; wd1 = 32'h44;
    tick();
    quiet();
    ra0 = 5'd7;
    ra1 = 5'd3;
    #1;
    tests++; if (rd0 !== 32'h2) begin fails++; $display("FAIL conflict_r7 got %h exp %h", rd0, 32'h2); end
    tests++; if (rd1 !== 32'h33) begin fails++; $display("FAIL dual_r3 got %h exp %h", rd1, 32'h33); end
    ra1 = 5'd4;
    #1;
    tests++; if (rd1 !== 32'h44) begin fails++; $display("FAIL dual_r4 got %h exp %h", rd1, 32'h44); end
  endtask

  task automatic test_scoreboard();
    set_busy = 1'b1; set_addr = 5'd9;
    tick();
    quiet();
    ra0 = 5'd9;
    #1;
    tests++; if (rb0 !== 1'b1) begin fails++; $display("FAIL busy_set got %b exp 1", rb0); end
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5;
    tick();
    quiet();
    #1;
    tests++; if (rb0 !== 1'b0) begin fails++; $display("FAIL busy_clear got %b exp 0", rb0); end
    tests++; if (rd0 !== 32'hA5) begin fails++; $display("FAIL busy_wr_data got %h exp %h", rd0, 32'hA5); end
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hA5;
    set_busy = 1'b1; set_addr = 5'd9;
    tick();
    quiet();
    #1;
    tests++; if (rb0 !== 1'b1) begin fails++; $display("FAIL set_wins_rb got %b exp 1", rb0); end
    tests++; if (rd0 !== 32'hA5) begin fails++; $display("FAIL set_wins_data got %h exp %h", rd0, 32'hA5); end
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt, done_at, bad;
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; wa0 = 5'(2 * i);     wd0 = 32'h1000_0000 + i;
      we1 = 1'b1; wa1 = 5'(2 * i + 1); wd1 = 32'h2000_0000 + i;
      set_busy = (i == 15); set_addr = 5'd31;
      tick();
    end
    quiet();
    ra0 = 5'd31;
    ra1 = 5'd30;
    #1;
    tests++; if (rd0 !== 32'h2000_000F) begin fails++; $display("FAIL fill_r31 got %h exp %h", rd0, 32'h2000_000F); end
    tests++; if (rb0 !== 1'b1) begin fails++; $display("FAIL fill_r31_busy got %b exp 1", rb0); end
    tests++; if (rd1 !== 32'h1000_000F) begin fails++; $display("FAIL fill_r30 got %h exp %h", rd1, 32'h1000_000F); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at = -1;
    for (int n = 0; n < 40; n++) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = n; end
      quiet();
      if (n == 3) clr_req = 1'b1;
      if (n == 5) begin we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hFFFF_FFFF; end
      if (n == 6) begin set_busy = 1'b1; set_addr = 5'd2; end
      if (n == 10) begin
        ra1 = 5'd31;
        #1;
        tests++; if (rd1 !== 32'h2000_000F) begin fails++; $display("FAIL sweep_read got %h exp %h", rd1, 32'h2000_000F); end
      end
      tick();
    end
    quiet();
    tests++; if (busy_cnt !== 32) begin fails++; $display("FAIL clr_busy_len got %0d exp 32", busy_cnt); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL clr_done_count got %0d exp 1", done_cnt); end
    tests++; if (done_at !== 32) begin fails++; $display("FAIL clr_done_time got %0d exp 32", done_at); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i);
      #1;
      if (rd0 !== 32'h0 || rb0 !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL cleared_entries got %0d nonzero exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hCAFE;
    clr_req = 1'b1;
    tick();
    quiet();
    repeat (10) tick();
    tests++; if (clr_busy !== 1'b1) begin fails++; $display("FAIL mid_sweep_busy got %b exp 1", clr_busy); end
    rst = 1'b1;
    #1;
    tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL abort_clr_busy got %b exp 0", clr_busy); end
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (clr_done === 1'b1 || clr_busy === 1'b1) done_cnt++;
      tick();
    end
    tests++; if (done_cnt !== 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
    ra0 = 5'd20;
    #1;
    tests++; if (rd0 !== 32'h0) begin fails++; $display("FAIL abort_data got %h exp %h", rd0, 32'h0); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rd;
    logic exp_rb;
`ifdef REGFILE_BYPASS_EN
    exp_rd = 32'h55;
    exp_rb = 1'b1;
`else
    exp_rd = 32'h77;
    exp_rb = 1'b0;
`endif
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h77;
    tick();
    wd0 = 32'h55;
    ra0 = 5'd2;
    set_busy = 1'b1; set_addr = 5'd4;
    ra1 = 5'd4;
    #1;
    tests++; if (rd0 !== exp_rd) begin fails++; $display("FAIL bypass_rd got %h exp %h", rd0, exp_rd); end
    tests++; if (rb0 !== 1'b0) begin fails++; $display("FAIL bypass_rb got %b exp 0", rb0); end
    tests++; if (rb1 !== exp_rb) begin fails++; $display("FAIL bypass_set_rb got %b exp %b", rb1, exp_rb); end
    tick();
    quiet();
    #1;
    tests++; if (rd0 !== 32'h55) begin fails++; $display("FAIL bypass_after got %h exp %h", rd0, 32'h55); end
    tests++; if (rb1 !== 1'b1) begin fails++; $display("FAIL bypass_busy_after got %b exp 1", rb1); end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_conflict();
    test_scoreboard();
    test_clear();
    test_reset_mid();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
